// File: rtl/io_port_controller_if.sv
// io_port_controller_if: bundles the CPU-side request bus and the peripheral IO bus.
// Latency: none (wires only). Backpressure: the controller holds cpu_wait high while a request is outstanding.
// Ports: cpu_port_id/cpu_read/cpu_write/cpu_wdata in, cpu_rdata/cpu_wait/cpu_done/cpu_err out (controller view);
//        io_sel/io_rd/io_wr/io_wdata out, io_rdata/io_ack in. The master modport is the controller; slave is its environment.
interface io_port_controller_if;
  logic [2:0] cpu_port_id;
  logic       cpu_read;
  logic       cpu_write;
  logic [3:0] cpu_wdata;
  logic [3:0] cpu_rdata;
  logic       cpu_wait;
  logic       cpu_done;
  logic       cpu_err;
  logic [7:0] io_sel;
  logic       io_rd;
  logic       io_wr;
  logic [3:0] io_wdata;
  logic [3:0] io_rdata;
  logic [7:0] io_ack;

  modport master (
    input  cpu_port_id, cpu_read, cpu_write, cpu_wdata, io_rdata, io_ack,
    output cpu_rdata, cpu_wait, cpu_done, cpu_err, io_sel, io_rd, io_wr, io_wdata
  );

  modport slave (
    output cpu_port_id, cpu_read, cpu_write, cpu_wdata, io_rdata, io_ack,
    input  cpu_rdata, cpu_wait, cpu_done, cpu_err, io_sel, io_rd, io_wr, io_wdata
  );
endinterface

// File: rtl/io_port_controller.sv
// io_port_controller: bridges one CPU read/write request at a time onto an 8-port one-hot IO bus.
// Latency: request edge to cpu_done is 2 cycles minimum (ack is sampled from the edge after REQ entry).
// Backpressure: cpu_wait stalls the CPU while in REQ; new requests are only taken in IDLE.
// Ports: clock, reset (async, active-high), bus (io_port_controller_if.master).
// Optional: define IO_TIMEOUT_EN to abort a request with cpu_err after TIMEOUT_CYCLES cycles without ack.
module io_port_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                        clock,
  input  logic                        reset,
  io_port_controller_if.master        bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] port_id;
  logic       is_read;
  logic [3:0] wdata;
  logic [3:0] rdata;
  logic       ack_hit;
  logic       start;
  logic       tmo_expire;

  // Only the acknowledge of the latched port counts; all other bits are ignored.
  assign ack_hit = bus.io_ack[port_id];
  // A legal request is exactly one of read/write; both together is an error.
  assign start   = (state == IDLE) && (bus.cpu_read ^ bus.cpu_write);

`ifdef IO_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;

  // Counts REQ cycles already spent; the last allowed cycle without ack aborts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= 8'd0;
    end else if (start) begin
      tmo_cnt <= 8'd0;
    end else if (state == REQ) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign tmo_expire = (tmo_cnt == TMO_LAST);
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Transaction context is captured once on acceptance so CPU-side changes during REQ are invisible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      port_id <= 3'd0;
      is_read <= 1'b0;
      wdata   <= 4'd0;
    end else if (start) begin
      port_id <= bus.cpu_port_id;
      is_read <= bus.cpu_read;
      wdata   <= bus.cpu_wdata;
    end
  end

  // Read data is captured on the ack edge and held until the next completed read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= 4'd0;
    end else if ((state == REQ) && ack_hit && is_read) begin
      rdata <= bus.io_rdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.cpu_read && bus.cpu_write) begin
          state_next = ERR;
        end else if (bus.cpu_read || bus.cpu_write) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack_hit) begin
          state_next = DONE;
        end else if (tmo_expire) begin
          state_next = ERR;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode from state only, so an asynchronous reset drops them immediately.
  always_comb begin
    bus.io_sel   = 8'd0;
    bus.io_rd    = 1'b0;
    bus.io_wr    = 1'b0;
    bus.io_wdata = 4'd0;
    bus.cpu_wait = 1'b0;
    bus.cpu_done = 1'b0;
    bus.cpu_err  = 1'b0;
    case (state)
      REQ: begin
        bus.io_sel   = 8'd1 << port_id;
        bus.io_rd    = is_read;
        bus.io_wr    = ~is_read;
        bus.io_wdata = wdata;
        bus.cpu_wait = 1'b1;
      end
      DONE:    bus.cpu_done = 1'b1;
      ERR:     bus.cpu_err  = 1'b1;
      default: ;
    endcase
  end

  assign bus.cpu_rdata = rdata;

endmodule

// File: tb/tb_io_port_controller.sv
// tb_io_port_controller: directed-vector bench for io_port_controller.
// Drives inputs and samples outputs 1 time unit after each rising edge.
// Ports: none (top-level bench); instantiates io_port_controller_if and the DUT.
module tb_io_port_controller;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  io_port_controller_if bus ();

  io_port_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_read    = 1'b0;
    bus.cpu_write   = 1'b0;
    bus.io_ack      = 8'h00;
  endtask

  initial begin
    int hi_cnt;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.cpu_port_id = 3'd0;
    bus.cpu_wdata   = 4'd0;
    bus.io_rdata    = 4'd0;
    idle_inputs();

    // Reset state
    #12;
    check("rst_sel",   {24'd0, bus.io_sel}, 32'h00);
    check("rst_wait",  {31'd0, bus.cpu_wait}, 32'd0);
    check("rst_done",  {31'd0, bus.cpu_done}, 32'd0);
    check("rst_err",   {31'd0, bus.cpu_err}, 32'd0);
    check("rst_rdata", {28'd0, bus.cpu_rdata}, 32'h0);
    #10;
    reset = 1'b0;

    // Write port 5, data A, ack after 3 REQ cycles; accepted on the first edge after reset
    bus.cpu_port_id = 3'd5;
    bus.cpu_wdata   = 4'hA;
    bus.cpu_write   = 1'b1;
    tick();
    // CPU side changes during REQ must not leak into the transaction
    bus.cpu_port_id = 3'd1;
    bus.cpu_wdata   = 4'h3;
    for (int i = 0; i < 3; i++) begin
      check("wr_sel",   {24'd0, bus.io_sel}, 32'h20);
      check("wr_wr",    {31'd0, bus.io_wr}, 32'd1);
      check("wr_rd",    {31'd0, bus.io_rd}, 32'd0);
      check("wr_wdata", {28'd0, bus.io_wdata}, 32'hA);
      check("wr_wait",  {31'd0, bus.cpu_wait}, 32'd1);
      check("wr_done0", {31'd0, bus.cpu_done}, 32'd0);
      if (i == 2) bus.io_ack = 8'h20;
      tick();
    end
    check("wr_done", {31'd0, bus.cpu_done}, 32'd1);
    check("wr_sel_done", {24'd0, bus.io_sel}, 32'h00);
    check("wr_wait_done", {31'd0, bus.cpu_wait}, 32'd0);
    idle_inputs();
    tick();
    check("wr_done_pulse", {31'd0, bus.cpu_done}, 32'd0);

    // Read port 2 with ack already high on the request edge: completes one edge later
    bus.cpu_port_id = 3'd2;
    bus.io_rdata    = 4'h6;
    bus.io_ack      = 8'h04;
    bus.cpu_read    = 1'b1;
    tick();
    check("rd_sel",   {24'd0, bus.io_sel}, 32'h04);
    check("rd_rd",    {31'd0, bus.io_rd}, 32'd1);
    check("rd_early", {31'd0, bus.cpu_done}, 32'd0);
    tick();
    check("rd_done",  {31'd0, bus.cpu_done}, 32'd1);
    check("rd_rdata", {28'd0, bus.cpu_rdata}, 32'h6);
    check("rd_rd_done", {31'd0, bus.io_rd}, 32'd0);
    idle_inputs();
    bus.io_rdata = 4'hF;
    tick();
    check("rd_hold", {28'd0, bus.cpu_rdata}, 32'h6);

    // Read port 3 while a foreign ack (port 4) pulses
    bus.cpu_port_id = 3'd3;
    bus.cpu_read    = 1'b1;
    tick();
    bus.io_ack = 8'h10;
    tick();
    check("fa_wait", {31'd0, bus.cpu_wait}, 32'd1);
    check("fa_done", {31'd0, bus.cpu_done}, 32'd0);
    bus.io_ack   = 8'h08;
    bus.io_rdata = 4'h9;
    tick();
    check("fa_done_ok", {31'd0, bus.cpu_done}, 32'd1);
    check("fa_rdata",   {28'd0, bus.cpu_rdata}, 32'h9);
    idle_inputs();
    tick();

    // Simultaneous read and write: one-cycle error, no strobes
    bus.cpu_read  = 1'b1;
    bus.cpu_write = 1'b1;
    tick();
    check("both_err",  {31'd0, bus.cpu_err}, 32'd1);
    check("both_sel",  {24'd0, bus.io_sel}, 32'h00);
    check("both_wait", {31'd0, bus.cpu_wait}, 32'd0);
    idle_inputs();
    tick();
    check("both_err_pulse", {31'd0, bus.cpu_err}, 32'd0);

    // No ack at all
    bus.cpu_port_id = 3'd1;
    bus.cpu_read    = 1'b1;
    tick();
`ifdef IO_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      check("tmo_wait", {31'd0, bus.cpu_wait}, 32'd1);
      tick();
    end
    check("tmo_err",   {31'd0, bus.cpu_err}, 32'd1);
    check("tmo_rdata", {28'd0, bus.cpu_rdata}, 32'h9);
    idle_inputs();
    tick();
    bus.cpu_port_id = 3'd6;
    bus.cpu_read    = 1'b1;
    tick();
`else
    hi_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.cpu_wait === 1'b1 && bus.cpu_err === 1'b0) hi_cnt++;
      tick();
    end
    check("nack_wait_cycles", hi_cnt, 100);
`endif
    check("mid_sel_pre", {31'd0, (bus.io_sel != 8'h00)}, 32'd1);

    // Reset in the middle of REQ drops outputs without a clock edge
    #2;
    reset = 1'b1;
    #1;
    check("arst_sel",   {24'd0, bus.io_sel}, 32'h00);
    check("arst_rd",    {31'd0, bus.io_rd}, 32'd0);
    check("arst_wait",  {31'd0, bus.cpu_wait}, 32'd0);
    check("arst_rdata", {28'd0, bus.cpu_rdata}, 32'h0);
    idle_inputs();
    #4;
    reset = 1'b0;

    // Next request after reset is accepted normally
    bus.cpu_port_id = 3'd0;
    bus.cpu_wdata   = 4'h5;
    bus.cpu_write   = 1'b1;
    tick();
    check("post_sel",   {24'd0, bus.io_sel}, 32'h01);
    check("post_wdata", {28'd0, bus.io_wdata}, 32'h5);
    bus.io_ack = 8'h01;
    tick();
    check("post_done", {31'd0, bus.cpu_done}, 32'd1);
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #50000;
    $display("FAIL timeout: simulation limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation limit");
  end

endmodule

// File: doc/io_port_controller.md
IO_PORT_CONTROLLER -- requirements
Module: io_port_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the ack wait limit in clock cycles (range 1..255) when IO_TIMEOUT_EN is defined.
REQ-002 clock  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 cpu_port_id  input  3  SHALL be the target port number from the control bus.
REQ-005 cpu_read  input  1  SHALL be the read request, level, held until cpu_done or cpu_err.
REQ-006 cpu_write  input  1  SHALL be the write request, same hold rule.
REQ-007 cpu_wdata  input  4  SHALL be the write data (datapath result bus).
REQ-008 cpu_rdata  output  4  SHALL be the registered read data returned to the datapath.
REQ-009 cpu_wait  output  1  SHALL be high while a transaction is outstanding (stall).
REQ-010 cpu_done  output  1  SHALL be a one-cycle completion pulse.
REQ-011 cpu_err  output  1  SHALL be a one-cycle error pulse.
REQ-012 io_sel  output  8  SHALL be the one-hot peripheral select.
REQ-013 io_rd, io_wr  output  1 each  SHALL be the peripheral read/write strobes.
REQ-014 io_wdata  output  4  SHALL be the latched write data to peripherals.
REQ-015 io_rdata  input  4  SHALL be the shared peripheral read bus.
REQ-016 io_ack  input  8  SHALL be the per-port acknowledge, one bit per port.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DONE, ERR.
- IDLE: exactly one of cpu_read/cpu_write high at edge -> latch port_id, direction, wdata; go REQ.
- IDLE: both cpu_read and cpu_write high -> ERR; no strobe issued.
- REQ: wait for io_ack[latched id]; on ack -> DONE; other ack bits SHALL be ignored.
- DONE, ERR: one cycle each, then IDLE.
REQ-018 In REQ, io_sel SHALL equal 1<<latched id, io_rd/io_wr SHALL match latched direction, io_wdata SHALL hold latched data; all zero in other states.
REQ-019 cpu_wait SHALL be high exactly in REQ; cpu_done high exactly in DONE; cpu_err high exactly in ERR.
REQ-020 On read ack, cpu_rdata SHALL load io_rdata on the ack edge and be valid in DONE; held until next completed read.
REQ-021 Request inputs SHALL be ignored in REQ, DONE, ERR; a request still high in IDLE after DONE starts a new transaction (requester drops it during cpu_done).
REQ-022 Ack already high on the edge entering REQ SHALL NOT complete; earliest completion is the edge after entering REQ (minimum latency: request edge to cpu_done = 2 cycles).
REQ-023 Port id or data changes during REQ SHALL NOT affect the transaction.

Reset
REQ-024 reset high SHALL immediately force IDLE and clear cpu_rdata, cpu_wait, cpu_done, cpu_err, io_sel, io_rd, io_wr, io_wdata, timeout counter to 0, including mid-transaction.
REQ-025 First transaction SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-026 With IO_TIMEOUT_EN defined, an 8-bit counter SHALL clear on REQ entry, increment each REQ cycle, and on reaching TIMEOUT_CYCLES without ack go ERR; cpu_rdata unchanged.
REQ-027 Without IO_TIMEOUT_EN, REQ SHALL wait indefinitely for ack; counter absent; cpu_err only from simultaneous read/write.

Verification
REQ-028 Write port 5, wdata 4'hA, io_ack[5] 3 cycles after strobe -> io_sel=8'h20, io_wr=1, io_wdata=4'hA for 3 cycles of REQ, one cpu_done pulse.
REQ-029 Read port 2, io_rdata=4'h6 with io_ack[2] -> cpu_rdata=4'h6 in DONE, held after; io_rd deasserted in DONE.
REQ-030 Read port 3 while io_ack[4] pulses, then io_ack[3] -> io_ack[4] ignored, completes only on io_ack[3].
REQ-031 cpu_read=cpu_write=1 in IDLE -> cpu_err one cycle, io_sel stays 0.
REQ-032 IO_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> cpu_err after 4 REQ cycles, cpu_rdata unchanged; without macro, cpu_wait stays high 100+ cycles.
REQ-033 reset asserted mid-REQ -> io_sel, io_rd, cpu_wait low without waiting for a clock edge; next request accepted normally.
